// File: rtl/fpu_result_arb.sv
// rtl/fpu_result_arb.sv - round-robin collector of FPU unit results into a tagged output FIFO
module fpu_result_arb #(
    parameter int NUM_UNITS = 9,
    parameter int WIDTH     = 32,
    parameter int FLAG_W    = 5,
    parameter int DEPTH     = 4,
    parameter int SRC_W     = $clog2(NUM_UNITS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_UNITS-1:0]          res_valid,
    input  logic [NUM_UNITS*WIDTH-1:0]    res_data,
    input  logic [NUM_UNITS*FLAG_W-1:0]   res_flags,
    output logic [NUM_UNITS-1:0]          res_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [FLAG_W-1:0]             out_flags,
    output logic [SRC_W-1:0]              out_src,
    input  logic                          clr_sticky,
    output logic [FLAG_W-1:0]             sticky_flags,
    output logic [$clog2(DEPTH):0]        fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = SRC_W + FLAG_W + WIDTH;
    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

    logic [SRC_W-1:0]  r_ptr;
    logic [AW-1:0]     r_wr;
    logic [AW-1:0]     r_rd;
    logic [AW:0]       r_level;
    logic [FLAG_W-1:0] r_sticky;
    logic [EW-1:0]     r_mem [DEPTH];

    logic              w_found;
    logic [SRC_W-1:0]  w_gnt_idx;
    logic [SRC_W-1:0]  w_ptr_nxt;
    logic              w_space;
    logic              w_push;
    logic              w_pop;
    logic [EW-1:0]     w_push_entry;
    logic [EW-1:0]     w_head;

    // First requester at or above the pointer, wrapping through the unit count.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (!w_found && res_valid[(int'(r_ptr) + k) % NUM_UNITS]) begin
                w_found   = 1'b1;
                w_gnt_idx = SRC_W'((int'(r_ptr) + k) % NUM_UNITS);
            end
        end
    end

    assign out_valid = (r_level != '0);
    assign w_pop     = out_valid && out_ready;
    assign w_space   = (r_level < LP_DEPTH) || w_pop;
    assign w_push    = rst_n && w_found && w_space;
    assign w_ptr_nxt = (w_gnt_idx == SRC_W'(NUM_UNITS-1)) ? '0 : w_gnt_idx + 1'b1;

    always_comb begin
        res_ready = '0;
        if (w_push)
            res_ready[w_gnt_idx] = 1'b1;
    end

    assign w_push_entry = {w_gnt_idx,
                           res_flags[w_gnt_idx*FLAG_W +: FLAG_W],
                           res_data[w_gnt_idx*WIDTH +: WIDTH]};

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr] <= w_push_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr    <= '0;
            r_wr     <= '0;
            r_rd     <= '0;
            r_level  <= '0;
            r_sticky <= '0;
        end else begin
            if (w_push) begin
                r_ptr <= w_ptr_nxt;
                r_wr  <= r_wr + 1'b1;
            end
            if (w_pop)
                r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            // Clear first, then keep whatever is popped in the same cycle.
            if (clr_sticky)
                r_sticky <= w_pop ? out_flags : '0;
            else if (w_pop)
                r_sticky <= r_sticky | out_flags;
        end
    end

    assign w_head       = r_mem[r_rd];
    assign out_data     = out_valid ? w_head[WIDTH-1:0] : '0;
    assign out_flags    = out_valid ? w_head[WIDTH +: FLAG_W] : '0;
    assign out_src      = out_valid ? w_head[WIDTH+FLAG_W +: SRC_W] : '0;
    assign sticky_flags = r_sticky;
    assign fifo_level   = r_level;

endmodule

// File: tb/tb_fpu_result_arb.sv
// tb/tb_fpu_result_arb.sv - scoreboard bench for fpu_result_arb with directed vectors
module tb_fpu_result_arb;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [8:0]   res_valid;
    logic [287:0] res_data;
    logic [44:0]  res_flags;
    logic [8:0]   res_ready;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [4:0]   out_flags;
    logic [3:0]   out_src;
    logic         clr_sticky;
    logic [4:0]   sticky_flags;
    logic [2:0]   fifo_level;

    typedef struct {
        logic [3:0]  src;
        logic [4:0]  flags;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fpu_result_arb dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .res_flags    (res_flags),
        .res_ready    (res_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_flags    (out_flags),
        .out_src      (out_src),
        .clr_sticky   (clr_sticky),
        .sticky_flags (sticky_flags),
        .fifo_level   (fifo_level)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_res(input int u, input logic [31:0] d, input logic [4:0] f);
        exp_t e;
        e.src   = 4'(u);
        e.flags = f;
        e.data  = d;
        q.push_back(e);
    endtask

    task automatic set_unit(input int u, input logic [31:0] d, input logic [4:0] f);
        res_data[u*32 +: 32] = d;
        res_flags[u*5 +: 5]  = f;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        res_valid  = '0;
        out_ready  = 1'b0;
        clr_sticky = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (fifo_level == 0) break;
        end
        chk("drain_level", 32'(fifo_level), 32'd0);
        chk("drain_queue_empty", 32'(q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic send(input int u, input logic [31:0] d, input logic [4:0] f);
        bit got;
        got = 1'b0;
        set_unit(u, d, f);
        res_valid[u] = 1'b1;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (res_ready[u]) begin
                got = 1'b1;
                expect_res(u, d, f);
            end
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
        end
        res_valid[u] = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: unit %0d never granted, required a grant", u);
        end
    endtask

    // Scoreboard monitor: every pop must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got src %0d data %h, expected no output", out_src, out_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pop_data", out_data, e.data);
                chk("pop_src", 32'(out_src), 32'(e.src));
                chk("pop_flags", 32'(out_flags), 32'(e.flags));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rr[6];
        rr = '{0, 3, 8, 0, 3, 8};
        res_data   = '0;
        res_flags  = '0;
        res_valid  = '0;
        out_ready  = 1'b0;
        clr_sticky = 1'b0;
        rst_n      = 1'b0;

        // Reset state, with a requester present that must not be granted
        res_valid[0] = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_res_ready", 32'(res_ready), 32'd0);
        chk("rst_sticky", 32'(sticky_flags), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_src", 32'(out_src), 32'd0);
        res_valid = '0;

        // Single result from unit 2
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        set_unit(2, 32'h3F80_0000, 5'b0);
        res_valid[2] = 1'b1;
        @(negedge clk);
        chk("single_ready", 32'(res_ready), 32'h004);
        expect_res(2, 32'h3F80_0000, 5'b0);
        @(posedge clk); #1;
        res_valid = '0;
        @(negedge clk);
        chk("single_out_valid", 32'(out_valid), 32'd1);
        chk("single_level", 32'(fifo_level), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("single_level_after_pop", 32'(fifo_level), 32'd0);

        // Round-robin among units 0, 3, 8
        do_reset();
        out_ready = 1'b1;
        set_unit(0, 32'hA000_0000, 5'b0);
        set_unit(3, 32'hA000_0003, 5'b0);
        set_unit(8, 32'hA000_0008, 5'b0);
        res_valid = 9'b1_0000_1001;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rr_grant", 32'(res_ready), 32'(1 << rr[i]));
            expect_res(rr[i], 32'hA000_0000 + 32'(rr[i]), 5'b0);
            @(posedge clk); #1;
        end
        res_valid = '0;
        drain();

        // Backpressure: fill to DEPTH, then push and pop together while full
        out_ready    = 1'b0;
        res_valid[1] = 1'b1;
        for (int n = 0; n < 4; n++) begin
            set_unit(1, 32'hB000_0000 + 32'(n), 5'b0);
            @(negedge clk);
            chk("bp_ready", 32'(res_ready), 32'h002);
            expect_res(1, 32'hB000_0000 + 32'(n), 5'b0);
            @(posedge clk); #1;
        end
        set_unit(1, 32'hB000_0004, 5'b0);
        @(negedge clk);
        chk("full_no_grant", 32'(res_ready), 32'd0);
        chk("full_level", 32'(fifo_level), 32'd4);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("full_pushpop_ready", 32'(res_ready), 32'h002);
        expect_res(1, 32'hB000_0004, 5'b0);
        @(posedge clk); #1;
        res_valid = '0;
        @(negedge clk);
        chk("full_pushpop_level", 32'(fifo_level), 32'd4);
        drain();

        // Sticky flags with a clear coinciding with a pop
        do_reset();
        out_ready = 1'b1;
        set_unit(4, 32'h0000_0001, 5'b00001);
        res_valid[4] = 1'b1;
        @(negedge clk);
        chk("sticky_ready_a", 32'(res_ready), 32'h010);
        expect_res(4, 32'h0000_0001, 5'b00001);
        @(posedge clk); #1;
        set_unit(4, 32'h0000_0002, 5'b10000);
        @(negedge clk);
        chk("sticky_ready_b", 32'(res_ready), 32'h010);
        expect_res(4, 32'h0000_0002, 5'b10000);
        @(posedge clk); #1;
        set_unit(4, 32'h0000_0003, 5'b00100);
        @(negedge clk);
        expect_res(4, 32'h0000_0003, 5'b00100);
        @(posedge clk); #1;
        res_valid  = '0;
        clr_sticky = 1'b1;
        @(negedge clk);
        chk("sticky_before_clr", 32'(sticky_flags), 32'b10001);
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        @(negedge clk);
        chk("sticky_after_clr", 32'(sticky_flags), 32'b00100);
        drain();

        // Reset in the middle of operation with pointer at 5
        do_reset();
        out_ready = 1'b0;
        set_unit(2, 32'hD000_0002, 5'b0);
        set_unit(3, 32'hD000_0003, 5'b0);
        set_unit(4, 32'hD000_0004, 5'b0);
        set_unit(1, 32'hD000_0001, 5'b0);
        set_unit(7, 32'hD000_0007, 5'b0);
        res_valid = 9'b0_0001_1100;
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            chk("fill_grant", 32'(res_ready), 32'(1 << i));
            expect_res(i, 32'hD000_0000 + 32'(i), 5'b0);
            @(posedge clk); #1;
        end
        res_valid = 9'b0_1000_0010;
        @(negedge clk);
        chk("ptr5_grant", 32'(res_ready), 32'h080);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_level", 32'(fifo_level), 32'd0);
        chk("midrst_res_ready", 32'(res_ready), 32'd0);
        q.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_grant", 32'(res_ready), 32'h002);
        expect_res(1, 32'hD000_0001, 5'b0);
        @(posedge clk); #1;
        res_valid[1] = 1'b0;
        @(negedge clk);
        chk("post_rst_grant2", 32'(res_ready), 32'h080);
        expect_res(7, 32'hD000_0007, 5'b0);
        @(posedge clk); #1;
        res_valid = '0;
        drain();

        // Ten results through the FIFO with random backpressure
        for (int n = 0; n < 10; n++)
            send((n % 2) ? 6 : 5, 32'hC000_0000 + 32'(n), 5'(n));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
